// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared encodings and size defaults for the register file write path
//
// Purpose: state encoding of the write-port sequencer and the register file
// geometry defaults shared with the register file and its address decoder.
package regfile_write_arbiter_pkg;

  // Sequencer state: INIT zero-fills every register, RUN serves requesters.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Register file geometry; DEF_NUM_REGS must equal 2**DEF_ADDR_W.
  localparam int DEF_WIDTH    = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_REGS = 32;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// rtl/regfile_write_arbiter_rr_arbiter2.sv - stateless two-way round-robin grant
//
// Purpose: picks one of two requesters. A lone requester always wins; when
// both request, the port that did not win last time is granted.
// Ports:
//   valid0, valid1 : request lines
//   last           : port granted on the most recent transfer (held by parent)
//   grant0, grant1 : one-hot (or zero) grant, purely combinational
module rr_arbiter2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  output logic grant0,
  output logic grant1
);

  // With both valid, last=1 favours port 0 and last=0 favours port 1.
  assign grant0 = valid0 & (~valid1 | last);
  assign grant1 = valid1 & (~valid0 | ~last);

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - zero-fill sequencer and round-robin arbiter for the register file write port
//
// Purpose: after reset or a clear request, writes zero to every register in
// address order; afterwards shares the single write port between the ALU
// writeback (port 0) and memory load (port 1) using valid/ready handshakes.
// Ports:
//   clk, rst_n            : clock and asynchronous active-low reset
//   clear                 : restart the zero-fill sequence
//   valid0/addr0/data0    : ALU writeback request
//   valid1/addr1/data1    : memory load request
//   ready0, ready1        : combinational grants; transfer on valid && ready
//   regwrite/waddr/wdata  : registered write command to the register file
//   init_done             : registered, high once the zero-fill has completed
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              valid0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [WIDTH-1:0]  data0,
  input  logic              valid1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [WIDTH-1:0]  data1,
  output logic              ready0,
  output logic              ready1,
  output logic              regwrite,
  output logic [ADDR_W-1:0] waddr,
  output logic [WIDTH-1:0]  wdata,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_e            state, state_d;
  logic [ADDR_W-1:0] cnt, cnt_d;
  logic              last, last_d;
  logic              regwrite_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [WIDTH-1:0]  wdata_d;
  logic              init_done_d;

  logic grant0, grant1;
  logic acc0, acc1;

  rr_arbiter2 u_rr (
    .valid0 (valid0),
    .valid1 (valid1),
    .last   (last),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  // clear suppresses ready so nothing is accepted on the edge that restarts
  // the walk; the requester simply keeps valid up and is served later.
  assign ready0 = (state == ST_RUN) && !clear && grant0;
  assign ready1 = (state == ST_RUN) && !clear && grant1;

  assign acc0 = valid0 & ready0;
  assign acc1 = valid1 & ready1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      cnt       <= '0;
      last      <= 1'b1;  // port 0 wins the first contested grant
      regwrite  <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      last      <= last_d;
      regwrite  <= regwrite_d;
      waddr     <= waddr_d;
      wdata     <= wdata_d;
      init_done <= init_done_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    last_d      = last;
    regwrite_d  = 1'b0;
    waddr_d     = waddr;
    wdata_d     = wdata;
    init_done_d = init_done;

    unique case (state)
      ST_INIT: begin
        if (clear) begin
          // Restart the walk; no write is issued on this edge.
          cnt_d       = '0;
          init_done_d = 1'b0;
        end else begin
          regwrite_d = 1'b1;
          waddr_d    = cnt;
          wdata_d    = '0;
          cnt_d      = cnt + 1'b1;
          if (cnt == LAST_ADDR) begin
            state_d     = ST_RUN;
            init_done_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (clear) begin
          state_d     = ST_INIT;
          cnt_d       = '0;
          init_done_d = 1'b0;
        end else if (acc0) begin
          // Register 0 is hardwired zero: accept the request but drop the write.
          regwrite_d = (addr0 != '0);
          waddr_d    = addr0;
          wdata_d    = data0;
          last_d     = 1'b0;
        end else if (acc1) begin
          regwrite_d = (addr1 != '0);
          waddr_d    = addr1;
          wdata_d    = data1;
          last_d     = 1'b1;
        end
      end

      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  typedef struct packed {
    logic        rw;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        done;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        valid0, valid1;
  logic [4:0]  addr0, addr1;
  logic [31:0] data0, data1;
  logic        ready0, ready1;
  logic        regwrite;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        init_done;

  int n_cmp = 0;
  int n_err = 0;
  wr_t sb[$];

  regfile_write_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .valid0    (valid0),
    .addr0     (addr0),
    .data0     (data0),
    .valid1    (valid1),
    .addr1     (addr1),
    .data1     (data1),
    .ready0    (ready0),
    .ready1    (ready1),
    .regwrite  (regwrite),
    .waddr     (waddr),
    .wdata     (wdata),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge: drive one cycle of requests, check the
  // combinational readys, queue the expected write, then compare it after
  // the rising edge and return at the next falling edge.
  task automatic step(input string tag,
                      input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                      input logic clr, input logic er0, input logic er1,
                      input logic erw, input logic [4:0] ewa, input logic [31:0] ewd,
                      input logic edone);
    wr_t e, got;
    valid0 = v0; addr0 = a0; data0 = d0;
    valid1 = v1; addr1 = a1; data1 = d1;
    clear  = clr;
    #1;
    check({tag, ".ready0"}, 32'(ready0), 32'(er0));
    check({tag, ".ready1"}, 32'(ready1), 32'(er1));
    e.rw = erw; e.wa = ewa; e.wd = ewd; e.done = edone;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({tag, ".regwrite"},  32'(regwrite),  32'(got.rw));
    check({tag, ".waddr"},     32'(waddr),     32'(got.wa));
    check({tag, ".wdata"},     wdata,          got.wd);
    check({tag, ".init_done"}, 32'(init_done), 32'(got.done));
    @(negedge clk);
  endtask

  task automatic idle_walk(input string tag, input logic v0, input logic v1, input int n);
    for (int i = 0; i < n; i++)
      step(tag, v0, 5'd3, 32'd50, v1, 5'd7, 32'd99, 1'b0, 1'b0, 1'b0,
           1'b1, 5'(i), 32'd0, (i == 31));
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0;
    valid0 = 1'b0; valid1 = 1'b0;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
    #2;
    check("rst.regwrite",  32'(regwrite),  32'd0);
    check("rst.waddr",     32'(waddr),     32'd0);
    check("rst.wdata",     wdata,          32'd0);
    check("rst.init_done", 32'(init_done), 32'd0);
    check("rst.ready0",    32'(ready0),    32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-fill after reset, no requests.
    idle_walk("walk", 1'b0, 1'b0, 32);
    step("idle", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0,
         1'b0, 5'd31, 32'd0, 1'b1);

    // Single requester on port 0 (last becomes 0).
    step("single", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0,
         1'b1, 5'd5, 32'hDEADBEEF, 1'b1);

    // Port 1 write to register 0: accepted, no write, last becomes 1.
    step("zero", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1,
         1'b0, 5'd0, 32'hFFFFFFFF, 1'b1);

    // Both valid: 0,1,0,1.
    for (int i = 0; i < 4; i++)
      step("rr", 1'b1, 5'd3, 32'd50, 1'b1, 5'd7, 32'd99, 1'b0,
           (i % 2 == 0), (i % 2 == 1), 1'b1,
           (i % 2 == 0) ? 5'd3 : 5'd7, (i % 2 == 0) ? 32'd50 : 32'd99, 1'b1);

    // Clear while both valid: no grant, init_done falls, outputs hold.
    step("clear", 1'b1, 5'd3, 32'd50, 1'b1, 5'd7, 32'd99, 1'b1, 1'b0, 1'b0,
         1'b0, 5'd7, 32'd99, 1'b0);
    idle_walk("rewalk", 1'b1, 1'b1, 32);
    step("resume", 1'b1, 5'd3, 32'd50, 1'b1, 5'd7, 32'd99, 1'b0, 1'b1, 1'b0,
         1'b1, 5'd3, 32'd50, 1'b1);

    // Restart the walk and reset it part-way through.
    step("clear2", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0,
         1'b0, 5'd3, 32'd50, 1'b0);
    for (int i = 0; i <= 12; i++)
      step("walk2", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0,
           1'b1, 5'(i), 32'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst.regwrite",  32'(regwrite),  32'd0);
    check("midrst.waddr",     32'(waddr),     32'd0);
    check("midrst.wdata",     wdata,          32'd0);
    check("midrst.init_done", 32'(init_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_walk("walk3", 1'b0, 1'b0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
